// File: rtl/lidar_pkg.sv
// Shared constants, state encoding and byte decode for the TF-LC02 host link.
// The receive-side decoder imports the same frame constants.
package lidar_pkg;

   localparam logic [7:0] HDR0        = 8'h55;
   localparam logic [7:0] HDR1        = 8'hAA;
   localparam logic [7:0] LEN         = 8'h00;
   localparam logic [7:0] TAIL        = 8'hFA;
   localparam int         FRAME_BYTES = 5;
   localparam logic [2:0] LAST_IDX    = 3'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   // Indices 5..7 cannot occur; they fall through to the tail byte.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] cmd);
      case (idx)
         3'd0:    frame_byte = HDR0;
         3'd1:    frame_byte = HDR1;
         3'd2:    frame_byte = cmd;
         3'd3:    frame_byte = LEN;
         default: frame_byte = TAIL;
      endcase
   endfunction

endpackage

// File: rtl/lidar_poll_timer.sv
// Idle-gap timer for auto polling: counts while enabled and flags terminal count.
// Terminal count sits at POLL_CYCLES so the gap spans POLL_CYCLES+1 clocks before the next SEND.
module lidar_poll_timer #(
   parameter int POLL_CYCLES = 5_000_000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_fClr,
   input  logic i_fEn,
   output logic o_fTc
);

   localparam int CW = $clog2(POLL_CYCLES + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(POLL_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   assign o_fTc = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (i_fClr)
         cnt_d = '0;
      else if (i_fEn && !o_fTc)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lidar_cmd_tx.sv
// Command-frame sequencer feeding the byte UART transmitter: 55 AA cmd 00 FA,
// with optional auto re-issue after a programmable idle gap.
//
//   state | meaning
//   IDLE  | waiting for a start request
//   SEND  | presenting current byte, strobing tx start once the transmitter is ready
//   WAIT  | byte in flight, waiting for the transmitter's done pulse
//   GAP   | auto-poll idle gap before re-sending the latched command
module lidar_cmd_tx
   import lidar_pkg::*;
#(
   parameter int POLL_CYCLES = 5_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_fStart,
   input  logic [7:0] i_Cmd,
   input  logic       i_fAuto,
   output logic       o_fBusy,
   output logic       o_fFrameDone,
   output logic       o_fTx,
   output logic [7:0] o_TxData,
   input  logic       i_fTxReady,
   input  logic       i_fTxDone
);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        gap_tc;
   logic        gap_clr;

   assign gap_clr = (state_q != ST_GAP) || !i_fAuto || gap_tc;

   lidar_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_poll_timer (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_fClr (gap_clr),
      .i_fEn  (state_q == ST_GAP),
      .o_fTc  (gap_tc)
   );

   assign o_TxData = frame_byte(idx_q, cmd_q);
   assign o_fBusy  = (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cmd_d        = cmd_q;
      o_fTx        = 1'b0;
      o_fFrameDone = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_fStart) begin
               cmd_d   = i_Cmd;
               idx_d   = 3'd0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i_fTxReady) begin
               o_fTx   = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_fTxDone) begin
               if (idx_q == LAST_IDX) begin
                  o_fFrameDone = 1'b1;
                  idx_d        = 3'd0;
                  state_d      = i_fAuto ? ST_GAP : ST_IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_SEND;
               end
            end
         end
         ST_GAP: begin
            if (!i_fAuto) begin
               state_d = ST_IDLE;
            end else if (gap_tc) begin
               idx_d   = 3'd0;
               state_d = ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         cmd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
      end
   end

endmodule

// File: tb/tb_lidar_cmd_tx.sv
// Bench for lidar_cmd_tx paired with a behavioural 4-clock-per-bit UART transmitter;
// a serial-line receiver pops expected bytes from a scoreboard queue.
module tb_lidar_cmd_tx;

   localparam int POLL = 20;
   localparam int CPB  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       auto_en = 1'b0;
   logic       stray_done = 1'b0;
   logic       stall = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       busy, fd, ftx;
   logic [7:0] txd;
   logic       tx_ready, tx_done, model_done;

   always #5 clk = ~clk;

   lidar_cmd_tx #(.POLL_CYCLES(POLL)) dut (
      .i_Clk        (clk),
      .i_Rst        (rst_n),
      .i_fStart     (start),
      .i_Cmd        (cmd),
      .i_fAuto      (auto_en),
      .o_fBusy      (busy),
      .o_fFrameDone (fd),
      .o_fTx        (ftx),
      .o_TxData     (txd),
      .i_fTxReady   (tx_ready),
      .i_fTxDone    (tx_done)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   // behavioural transmitter: start bit, 8 data bits LSB first, stop bit
   logic       m_busy;
   int         m_bit, m_cnt;
   logic [7:0] m_shift;
   logic       line;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_bit <= 0; m_cnt <= 0; m_shift <= 8'h00;
      end else if (!m_busy) begin
         if (ftx) begin
            m_busy <= 1'b1; m_shift <= txd; m_bit <= 0; m_cnt <= 0;
         end
      end else if (m_cnt == CPB - 1) begin
         m_cnt <= 0;
         if (m_bit == 9) m_busy <= 1'b0;
         else            m_bit  <= m_bit + 1;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   assign tx_ready   = !m_busy && !stall;
   assign model_done = m_busy && (m_bit == 9) && (m_cnt == CPB - 1);
   assign tx_done    = model_done || stray_done;

   always_comb begin
      line = 1'b1;
      if (m_busy) begin
         if (m_bit == 0)      line = 1'b0;
         else if (m_bit == 9) line = 1'b1;
         else                 line = m_shift[m_bit-1];
      end
   end

   // serial receiver: samples mid-bit, compares each byte against the scoreboard
   bit         r_act = 1'b0;
   int         r_cnt = 0;
   logic [7:0] r_byte = 8'h00;
   logic [7:0] r_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         r_act = 1'b0;
      end else if (!r_act) begin
         if (line == 1'b0) begin r_act = 1'b1; r_cnt = 0; end
      end else begin
         r_cnt++;
         if (r_cnt >= 6 && r_cnt <= 34 && ((r_cnt - 6) % CPB) == 0)
            r_byte[(r_cnt-6)/CPB] = line;
         if (r_cnt == 4*9 + 2) begin
            r_act = 1'b0;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rx_unexpected: got byte %02h, expected none", r_byte);
            end else begin
               r_exp = exp_q.pop_front();
               if (r_byte !== r_exp || line !== 1'b1) begin
                  n_err++;
                  $display("FAIL rx_byte: got %02h stop=%b, expected %02h stop=1", r_byte, line, r_exp);
               end
            end
         end
      end
   end

   // event monitor
   int tx_pulses = 0, fd_cnt = 0, fd_bad = 0, frame_dones = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         frame_dones = 0;
      end else begin
         if (ftx) tx_pulses++;
         if (ftx && txd == 8'h55) frame_dones = 0;
         if (model_done) frame_dones++;
         if (fd) begin
            fd_cnt++;
            if (!model_done || frame_dones != 5) fd_bad++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] c);
      exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(c);
      exp_q.push_back(8'h00); exp_q.push_back(8'hFA);
   endtask

   task automatic pulse_start(input logic [7:0] c);
      @(posedge clk); #1;
      cmd = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_fd(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (fd) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_timeout: no frame-done within 400 cycles, expected one", name);
      end
   endtask

   task automatic wait_byte(input logic [7:0] b, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ftx && txd == b) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_timeout: byte %02h never started, expected it", name, b);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (ftx !== 1'b0)    begin n_err++; $display("FAIL rst_tx: got %b, expected 0", ftx); end
      n_cmp++; if (txd !== 8'h55)   begin n_err++; $display("FAIL rst_txdata: got %02h, expected 55", txd); end
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      n_cmp++; if (fd !== 1'b0)     begin n_err++; $display("FAIL rst_fd: got %b, expected 0", fd); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single();
      int fd0 = fd_cnt;
      int bad0 = fd_bad;
      auto_en = 1'b0;
      push_frame(8'h02);
      pulse_start(8'h02);
      @(negedge clk);
      n_cmp++; if (ftx !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL single_first_tx: tx=%b busy=%b, expected 1 1", ftx, busy);
      end
      wait_fd("single");
      tick(5);
      n_cmp++; if (fd_bad !== bad0) begin n_err++; $display("FAIL single_fd_align: bad=%0d, expected %0d", fd_bad, bad0); end
      n_cmp++; if (fd_cnt !== fd0 + 1) begin n_err++; $display("FAIL single_fd_count: got %0d, expected %0d", fd_cnt, fd0 + 1); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy=%b, expected 0", busy); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_drain: %0d bytes left, expected 0", exp_q.size()); end
   endtask

   task automatic test_auto();
      int k = 0;
      int tx0;
      bit gap_busy_ok = 1'b1;
      auto_en = 1'b1;
      push_frame(8'h02);
      push_frame(8'h02);
      pulse_start(8'h02);
      wait_fd("auto1");
      for (int i = 0; i < 3*POLL; i++) begin
         @(negedge clk);
         k++;
         if (ftx) break;
         if (busy !== 1'b1) gap_busy_ok = 1'b0;
      end
      n_cmp++; if (k !== POLL + 2) begin n_err++; $display("FAIL auto_gap: next tx %0d cycles after done, expected %0d", k, POLL + 2); end
      n_cmp++; if (!gap_busy_ok) begin n_err++; $display("FAIL auto_gap_busy: busy dropped in gap, expected high"); end
      wait_fd("auto2");
      @(posedge clk); #1;
      auto_en = 1'b0;
      tx0 = tx_pulses;
      tick(3*POLL);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL auto_stop_busy: got %b, expected 0", busy); end
      n_cmp++; if (tx_pulses !== tx0) begin n_err++; $display("FAIL auto_stop_tx: %0d pulses, expected %0d", tx_pulses, tx0); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL auto_drain: %0d bytes left, expected 0", exp_q.size()); end
   endtask

   task automatic test_ignored();
      int fd0 = fd_cnt;
      push_frame(8'h02);
      pulse_start(8'h02);
      wait_byte(8'hAA, "ign_byte1");
      @(posedge clk); #1;
      cmd = 8'h05; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_fd("ign");
      tick(100);
      n_cmp++; if (fd_cnt !== fd0 + 1) begin n_err++; $display("FAIL ign_fd_count: got %0d, expected %0d", fd_cnt, fd0 + 1); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle: busy=%b, expected 0", busy); end
      @(posedge clk); #1;
      stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || ftx !== 1'b0 || txd !== 8'h55) begin
         n_err++; $display("FAIL stray_done: busy=%b tx=%b data=%02h, expected 0 0 55", busy, ftx, txd);
      end
   endtask

   task automatic test_stall();
      int stall_bad = 0;
      int tx0;
      stall = 1'b1;
      push_frame(8'hC3);
      pulse_start(8'hC3);
      repeat (10) begin
         @(negedge clk);
         if (ftx !== 1'b0 || busy !== 1'b1) stall_bad++;
      end
      n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL stall_hold: %0d bad cycles, expected 0", stall_bad); end
      tx0 = tx_pulses;
      @(posedge clk); #1;
      stall = 1'b0;
      @(negedge clk);
      n_cmp++; if (ftx !== 1'b1) begin n_err++; $display("FAIL stall_release: tx=%b, expected 1", ftx); end
      @(negedge clk);
      n_cmp++; if (ftx !== 1'b0) begin n_err++; $display("FAIL stall_single: tx=%b, expected 0", ftx); end
      wait_fd("stall");
      tick(5);
      n_cmp++; if (tx_pulses - tx0 !== 5) begin n_err++; $display("FAIL stall_pulses: got %0d, expected 5", tx_pulses - tx0); end
   endtask

   task automatic test_reset_mid();
      push_frame(8'h3C);
      pulse_start(8'h3C);
      wait_byte(8'h00, "rmid_byte3");
      repeat (10) @(posedge clk);
      #2;
      n_cmp++; if (exp_q.size() !== 2) begin n_err++; $display("FAIL rmid_progress: %0d bytes left, expected 2", exp_q.size()); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ftx !== 1'b0 || txd !== 8'h55 || busy !== 1'b0) begin
         n_err++; $display("FAIL rmid_async: tx=%b data=%02h busy=%b, expected 0 55 0", ftx, txd, busy);
      end
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);
      push_frame(8'h81);
      pulse_start(8'h81);
      wait_fd("rmid_new");
      tick(5);
      n_cmp++; if (exp_q.size() !== 0 || busy !== 1'b0) begin
         n_err++; $display("FAIL rmid_new_frame: %0d bytes left busy=%b, expected 0 0", exp_q.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_auto();
      test_ignored();
      test_stall();
      test_reset_mid();
      tick(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
